// File: rtl/riscv_pkg.sv
// Shared fetch definitions: NOP word, reset PC, fetch FSM encoding and the
// {instr, pc} pair carried through the hold buffer.
package riscv_pkg;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a returned {instr, pc} while decode is stalled.
module fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr,
  input  fetch_word_t i_word,
  input  logic        i_rd,
  input  logic        i_clr,
  output logic        o_valid,
  output fetch_word_t o_word
);

  logic        r_valid;
  fetch_word_t r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else begin
      if (i_clr)     r_valid <= 1'b0;
      else if (i_wr) r_valid <= 1'b1;
      else if (i_rd) r_valid <= 1'b0;
      if (i_wr) r_word <= i_word;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns pcF, keeps one imem read outstanding, fills IF/ID.
// Optional FETCH_MISALIGN_CHECK_EN: word-aligns redirect targets and flags o_MisalignF.
//   state  | meaning
//   F_IDLE | no read outstanding
//   F_WAIT | read granted, response pending
//   F_DROP | next response is stale and is discarded
module if_fetch
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_ImemReq,
  output logic [31:0] o_ImemAddr,
  input  logic        i_ImemGnt,
  input  logic        i_ImemValid,
  input  logic [31:0] i_ImemData,
  input  logic        i_Stall,
  input  logic        i_FlushD,
  input  logic        i_PcSrcE,
  input  logic [31:0] i_PcTargetE,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        o_MisalignF,
`endif
  output logic [31:0] o_InstrD,
  output logic [31:0] o_PcD,
  output logic [31:0] o_PcPlus4D,
  output logic        o_ValidD
);

  fetch_state_e r_state, w_stateNext;
  logic [31:0]  r_pcF, r_reqPc;
  logic [31:0]  r_instrD, r_pcD, r_pcPlus4D;
  logic         r_validD;
  logic [31:0]  w_target;
  logic         w_req, w_fire, w_rsp;
  logic         w_hbValid, w_hbWr, w_hbRd;
  fetch_word_t  w_hbWord;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  assign w_target = {i_PcTargetE[31:2], 2'b00};
  always_ff @(posedge clk) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= i_PcSrcE && (i_PcTargetE[1:0] != 2'b00);
  end
  assign o_MisalignF = r_misalign;
`else
  assign w_target = i_PcTargetE;
`endif

  // A new read may issue from IDLE, or back-to-back as the pending one returns.
  assign w_req  = rst_n && !w_hbValid && !i_Stall && !i_PcSrcE &&
                  ((r_state == F_IDLE) || ((r_state == F_WAIT) && i_ImemValid));
  assign w_fire = w_req && i_ImemGnt;
  assign w_rsp  = (r_state == F_WAIT) && i_ImemValid && !i_PcSrcE;
  assign w_hbWr = w_rsp && i_Stall;
  assign w_hbRd = w_hbValid && !i_Stall && !i_FlushD && !i_PcSrcE;

  fetch_hold_buf u_hb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_hbWr),
    .i_word  ('{instr: i_ImemData, pc: r_reqPc}),
    .i_rd    (w_hbRd),
    .i_clr   (i_PcSrcE),
    .o_valid (w_hbValid),
    .o_word  (w_hbWord)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= F_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      F_IDLE: if (w_fire) w_stateNext = F_WAIT;
      F_WAIT: begin
        if (i_PcSrcE)        w_stateNext = i_ImemValid ? F_IDLE : F_DROP;
        else if (i_ImemValid) w_stateNext = w_fire ? F_WAIT : F_IDLE;
      end
      F_DROP: if (i_ImemValid) w_stateNext = F_IDLE;
      default: w_stateNext = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcF   <= RESET_PC;
      r_reqPc <= RESET_PC;
    end else begin
      if (i_PcSrcE)    r_pcF <= w_target;
      else if (w_fire) r_pcF <= r_pcF + 32'd4;
      if (w_fire) r_reqPc <= r_pcF;
    end
  end

  // Flush beats stall; a bubble keeps the previous PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instrD   <= NOP;
      r_pcD      <= 32'd0;
      r_pcPlus4D <= 32'd4;
      r_validD   <= 1'b0;
    end else if (i_FlushD || (!i_Stall && (i_PcSrcE || !(w_hbValid || w_rsp)))) begin
      r_instrD <= NOP;
      r_validD <= 1'b0;
    end else if (!i_Stall) begin
      r_validD <= 1'b1;
      if (w_hbValid) begin
        r_instrD   <= w_hbWord.instr;
        r_pcD      <= w_hbWord.pc;
        r_pcPlus4D <= w_hbWord.pc + 32'd4;
      end else begin
        r_instrD   <= i_ImemData;
        r_pcD      <= r_reqPc;
        r_pcPlus4D <= r_reqPc + 32'd4;
      end
    end
  end

  assign o_ImemReq  = w_req;
  assign o_ImemAddr = r_pcF;
  assign o_InstrD   = r_instrD;
  assign o_PcD      = r_pcD;
  assign o_PcPlus4D = r_pcPlus4D;
  assign o_ValidD   = r_validD;

endmodule
